// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : wide_add_seq
// Description : Sequential wide adder. Operands arrive as 16-bit slices,
//               least-significant slice first, and are summed one slice per
//               cycle through an external 16-bit adder. The carry is chained
//               between slices. Two-stage pipeline: operand register, then
//               result register, with valid/ready flow control on both sides.
//               Optional macro WIDE_ADD_SEQ_SUB_EN adds port in_sub so that
//               an operation can compute a-b instead of a+b.
// Revision    : 1.0 - initial release
// ============================================================================
module wide_add_seq #(
  parameter int BEAT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  // upstream slice stream
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_a,
  input  logic [15:0]       in_b,
  input  logic              in_first,
  input  logic              in_last,
`ifdef WIDE_ADD_SEQ_SUB_EN
  input  logic              in_sub,
`endif
  // external 16-bit adder
  output logic [15:0]       add_a,
  output logic [15:0]       add_b,
  output logic              add_cin,
  input  logic [16:0]       add_sum,
  // downstream result stream
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_sum,
  output logic              out_carry,
  output logic              out_last,
  output logic [BEAT_W-1:0] out_beat,
  output logic              err
);

  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;
  localparam logic [BEAT_W-1:0] BEAT_ONE = {{(BEAT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,   // next accepted slice starts an operation
    ST_BUSY = 1'b1    // inside an operation, expecting continuation slices
  } state_t;

  state_t state_q, state_d;

  // operand stage
  logic              op_valid_q, op_valid_d;
  logic [15:0]       op_a_q,     op_a_d;
  logic [15:0]       op_b_q,     op_b_d;
  logic              op_cin_q,   op_cin_d;
  logic              op_last_q,  op_last_d;
  logic [BEAT_W-1:0] op_beat_q,  op_beat_d;

  // result stage
  logic              out_valid_q, out_valid_d;
  logic [15:0]       out_sum_q,   out_sum_d;
  logic              out_carry_q, out_carry_d;
  logic              out_last_q,  out_last_d;
  logic [BEAT_W-1:0] out_beat_q,  out_beat_d;

  // operation-level bookkeeping
  logic              carry_q, carry_d;     // carry-out of last retired slice
  logic [BEAT_W-1:0] beat_q,  beat_d;      // index the next slice will take
  logic              err_q,   err_d;

`ifdef WIDE_ADD_SEQ_SUB_EN
  logic              op_sub_q,   op_sub_d;   // subtract flag of slice in op stage
  logic              sub_mode_q, sub_mode_d; // subtract flag of current operation
`endif

  // decoded per-slice attributes
  logic              accept;
  logic              op_adv;
  logic              eff_first;
  logic              wrap;
  logic              slice_last;
  logic              frame_err;
  logic [BEAT_W-1:0] slice_beat;
  logic              slice_sub;
  logic              slice_cin;

  // Flow control: the op stage retires whenever the result stage is free or
  // being drained; a new slice can enter whenever the op stage is empty or
  // retiring in the same cycle.
  assign op_adv   = op_valid_q & (~out_valid_q | out_ready);
  assign in_ready = ~op_valid_q | ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // Operands to the external adder come straight from the op stage.
  assign add_a   = op_a_q;
`ifdef WIDE_ADD_SEQ_SUB_EN
  assign add_b   = op_sub_q ? ~op_b_q : op_b_q;
  assign slice_sub = eff_first ? in_sub : sub_mode_q;
`else
  assign add_b   = op_b_q;
  assign slice_sub = 1'b0;
`endif
  assign add_cin = op_cin_q;

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;
  assign out_last  = out_last_q;
  assign out_beat  = out_beat_q;
  assign err       = err_q;

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame decode of the presented slice and next frame state.
  always_comb begin
    state_d    = state_q;
    // A slice seen while idle starts an operation even without in_first,
    // and in_first while busy restarts the operation.
    eff_first  = in_first | (state_q == ST_IDLE);
    slice_beat = eff_first ? '0 : beat_q;
    // Running out of beat indices closes the operation on this slice.
    wrap       = (slice_beat == BEAT_MAX) & ~in_last;
    slice_last = in_last | wrap;
    frame_err  = ((state_q == ST_IDLE) & ~in_first) |
                 ((state_q == ST_BUSY) &  in_first) |
                 wrap;
    if (accept) begin
      state_d = slice_last ? ST_IDLE : ST_BUSY;
    end
  end

  // Carry-in selection: a first slice starts from 0 (1 when subtracting);
  // otherwise the previous slice is either in the op stage right now (its
  // carry is live on add_sum) or has already retired into carry_q.
  always_comb begin
    slice_cin = carry_q;
    if (eff_first) begin
      slice_cin = slice_sub;
    end else if (op_valid_q) begin
      slice_cin = add_sum[16];
    end
  end

  // Next-state for the operand stage, result stage and bookkeeping.
  always_comb begin
    op_valid_d  = op_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    op_last_d   = op_last_q;
    op_beat_d   = op_beat_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    out_last_d  = out_last_q;
    out_beat_d  = out_beat_q;
    carry_d     = carry_q;
    beat_d      = beat_q;
    err_d       = err_q;
`ifdef WIDE_ADD_SEQ_SUB_EN
    op_sub_d    = op_sub_q;
    sub_mode_d  = sub_mode_q;
`endif

    // Result stage: load on retire, otherwise empty once consumed.
    if (op_adv) begin
      out_valid_d = 1'b1;
      out_sum_d   = add_sum[15:0];
      out_carry_d = add_sum[16];
      out_last_d  = op_last_q;
      out_beat_d  = op_beat_q;
      carry_d     = add_sum[16];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Operand stage: load on acceptance, otherwise empty once retired.
    if (accept) begin
      op_valid_d = 1'b1;
      op_a_d     = in_a;
      op_b_d     = in_b;
      op_cin_d   = slice_cin;
      op_last_d  = slice_last;
      op_beat_d  = slice_beat;
      beat_d     = slice_beat + BEAT_ONE;
      if (frame_err) begin
        err_d = 1'b1;
      end
`ifdef WIDE_ADD_SEQ_SUB_EN
      op_sub_d   = slice_sub;
      sub_mode_d = slice_sub;
`endif
    end else if (op_adv) begin
      op_valid_d = 1'b0;
    end
  end

  // Pipeline and bookkeeping registers; reset drops any in-flight slices.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      op_last_q   <= 1'b0;
      op_beat_q   <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_beat_q  <= '0;
      carry_q     <= 1'b0;
      beat_q      <= '0;
      err_q       <= 1'b0;
`ifdef WIDE_ADD_SEQ_SUB_EN
      op_sub_q    <= 1'b0;
      sub_mode_q  <= 1'b0;
`endif
    end else begin
      op_valid_q  <= op_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      op_last_q   <= op_last_d;
      op_beat_q   <= op_beat_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
      out_last_q  <= out_last_d;
      out_beat_q  <= out_beat_d;
      carry_q     <= carry_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
`ifdef WIDE_ADD_SEQ_SUB_EN
      op_sub_q    <= op_sub_d;
      sub_mode_q  <= sub_mode_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_wide_add_seq
// Description : Scoreboard bench for wide_add_seq. The driver pushes the
//               hand-computed result of each slice when the slice is
//               accepted; an independent monitor pops and compares on every
//               output handshake. Models the external adder behaviourally.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_add_seq;

  localparam int BW = 4;

  typedef struct packed {
    logic [15:0]   sum;
    logic          carry;
    logic          last;
    logic [BW-1:0] beat;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_a;
  logic [15:0]   in_b;
  logic          in_first;
  logic          in_last;
`ifdef WIDE_ADD_SEQ_SUB_EN
  logic          in_sub;
`endif
  logic [15:0]   add_a;
  logic [15:0]   add_b;
  logic          add_cin;
  logic [16:0]   add_sum;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_sum;
  logic          out_carry;
  logic          out_last;
  logic [BW-1:0] out_beat;
  logic          err;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  wide_add_seq #(.BEAT_W(BW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_first (in_first),
    .in_last  (in_last),
`ifdef WIDE_ADD_SEQ_SUB_EN
    .in_sub   (in_sub),
`endif
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_carry(out_carry),
    .out_last (out_last),
    .out_beat (out_beat),
    .err      (err)
  );

  // external 16-bit adder
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, req);
    end
  endtask

  // monitor: compare on every output handshake, and check hold while stalled
  exp_t          held;
  logic          prev_stall = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (!rst) begin
      a = '{sum: out_sum, carry: out_carry, last: out_last, beat: out_beat};
      if (prev_stall) begin
        total++;
        if (!out_valid || a !== held) begin
          bad++;
          $display("FAIL hold: valid=%0b got %h expected %h", out_valid, a, held);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: sum=%h beat=%0d, none expected", out_sum, out_beat);
        end else begin
          e = sb_q.pop_front();
          if (out_sum !== e.sum || out_last !== e.last || out_beat !== e.beat ||
              (e.last && out_carry !== e.carry)) begin
            bad++;
            $display("FAIL slice: got sum=%h c=%0b last=%0b beat=%0d expected sum=%h c=%0b last=%0b beat=%0d",
                     out_sum, out_carry, out_last, out_beat, e.sum, e.carry, e.last, e.beat);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      held = a;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // drive one slice; called and returns at posedge+1
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic f, input logic l,
                      input logic [15:0] es, input logic ec, input logic el,
                      input logic [BW-1:0] eb, input logic push);
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_first = f;
    in_last  = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
        break;
      end
    end
    @(posedge clk);
    if (push) sb_q.push_back('{sum: es, carry: ec, last: el, beat: eb});
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid) break;
      n++;
      if (n > 60) begin
        total++;
        bad++;
        $display("FAIL drain_timeout: pending=%0d expected 0", sb_q.size());
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_64bit_plus_one();
    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd1, 1'b1);
    send(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 4'd2, 1'b1);
    send(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 4'd3, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
`ifdef WIDE_ADD_SEQ_SUB_EN
    in_sub    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_err", err, 1'b0);
    check1("rst_out_sum_zero", out_sum == 16'h0000, 1'b1);
    check1("rst_out_beat_zero", out_beat == '0, 1'b1);
    check1("rst_out_last", out_last, 1'b0);
    check1("rst_out_carry", out_carry, 1'b0);
    @(posedge clk);
    #1;

    // single slice with carry-out, 2-cycle latency
    send(16'hFFFF, 16'h0001, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 4'd0, 1'b1);
    @(negedge clk);
    check1("lat_op_stage", out_valid, 1'b0);
    @(negedge clk);
    check1("lat_out_stage", out_valid, 1'b1);
    @(posedge clk);
    #1;
    wait_drain();

    // 4-slice carry propagation, back to back
    send_64bit_plus_one();
    wait_drain();

    // same op with downstream stalled 3 cycles on slice 1
    fork
      send_64bit_plus_one();
      begin : stall_proc
        int n;
        n = 0;
        forever begin
          @(negedge clk);
          if (out_valid && out_ready && out_beat == 4'd0) break;
          n++;
          if (n > 50) begin
            total++;
            bad++;
            $display("FAIL stall_wait: beat0 never seen");
            break;
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check1("stall_in_ready", in_ready, 1'b0);
        check1("stall_beat1_held", out_valid && out_beat == 4'd1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check1("no_err_clean_ops", err, 1'b0);

    // reset mid-operation discards the in-flight slice
    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check1("rstmid_out_valid_a", out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check1("rstmid_out_valid_b", out_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check1("rstmid_out_valid_c", out_valid, 1'b0);
    check1("rstmid_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    send(16'h1234, 16'h4321, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b1, 4'd0, 1'b1);
    wait_drain();

    // missing in_first after idle: treated as first, err is sticky
    send(16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b1, 4'd0, 1'b1);
    @(negedge clk);
    check1("err_set", err, 1'b1);
    @(posedge clk);
    #1;
    wait_drain();
    send(16'h0010, 16'h0020, 1'b1, 1'b1, 16'h0030, 1'b0, 1'b1, 4'd0, 1'b1);
    wait_drain();
    check1("err_sticky", err, 1'b1);
    do_reset();
    @(negedge clk);
    check1("err_cleared", err, 1'b0);
    @(posedge clk);
    #1;

`ifdef WIDE_ADD_SEQ_SUB_EN
    // 0x0001_0000 - 0x0000_0001 = 0x0000_FFFF, no borrow
    in_sub = 1'b1;
    send(16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 4'd0, 1'b1);
    in_sub = 1'b0;
    send(16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 4'd1, 1'b1);
    wait_drain();
    check1("sub_no_err", err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter BEAT_W, default 4: width of the beat counter (max beats per operation 2^BEAT_W).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream beat valid.
REQ-005 SHALL have port in_ready  output  1  beat accepted when in_valid and in_ready are both high at clk rise.
REQ-006 SHALL have port in_a, in_b  input  16 each  operand slices, least-significant slice first.
REQ-007 SHALL have port in_first  input  1  first slice of an operation.
REQ-008 SHALL have port in_last  input  1  last slice of an operation.
REQ-009 SHALL have port add_a, add_b  output  16 each  operands driven to the external 16-bit KGP adder.
REQ-010 SHALL have port add_cin  output  1  adder carry-in.
REQ-011 SHALL have port add_sum  input  17  adder result; bit 16 is carry-out; combinational from add_a/add_b/add_cin.
REQ-012 SHALL have port out_valid  output  1  result slice valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts.
REQ-014 SHALL have port out_sum  output  16  result slice.
REQ-015 SHALL have port out_carry  output  1  final carry-out; meaningful only with out_last.
REQ-016 SHALL have port out_last  output  1  last slice of the operation.
REQ-017 SHALL have port out_beat  output  BEAT_W  slice index within the operation, 0 for the first.
REQ-018 SHALL have port err  output  1  sticky framing error.

Function
REQ-019 SHALL be a two-stage pipeline: operand register (op_*) feeding add_a/add_b, then result register feeding out_*.
REQ-020 SHALL set in_ready = !op_valid | !out_valid | out_ready; op stage advances into result stage when result stage empty or out_ready high.
REQ-021 SHALL set add_cin on acceptance to 0 when in_first, else to add_sum[16] if op stage holds the previous slice, else to the stored carry register.
REQ-022 SHALL capture add_sum[15:0] into out_sum and add_sum[16] into out_carry and the carry register when op stage retires.
REQ-023 SHALL give latency 2 cycles from acceptance to out_valid with out_ready held high; throughput 1 slice/cycle.
REQ-024 SHALL hold out_* stable while out_valid high and out_ready low; no slice dropped or duplicated.
REQ-025 SHALL implement states IDLE (expecting first) and BUSY (mid-operation): IDLE->BUSY on accepted first without last; BUSY->IDLE on accepted last; first+last in IDLE stays IDLE.
REQ-026 SHALL treat a slice without in_first in IDLE as first (cin 0) and set err.
REQ-027 SHALL treat in_first in BUSY as restart (cin 0, beat 0) and set err.
REQ-028 SHALL increment beat counter per accepted slice, reset to 0 on first; counter wrap at 2^BEAT_W without last SHALL set err and force out_last on the wrapping slice.

Reset
REQ-029 SHALL on rst clear op_valid, out_valid, out_sum, out_carry, out_last, out_beat, err, carry register and enter IDLE; in_ready = 1 the cycle after rst falls.
REQ-030 SHALL let rst mid-operation discard all in-flight slices with no output beat emitted.

Configuration
REQ-031 SHALL with macro WIDE_ADD_SEQ_SUB_EN defined add port in_sub (input 1, sampled with in_first, held for the operation): add_b = ~op_b and first-slice cin = 1, computing a-b; out_carry = 1 means no borrow.
REQ-032 SHALL without WIDE_ADD_SEQ_SUB_EN have no in_sub port and perform addition only.

Verification
REQ-033 SHALL cover: one slice first+last a=0xFFFF b=0x0001 -> out_sum=0x0000, out_carry=1, out_beat=0, 2-cycle latency.
REQ-034 SHALL cover: 4-slice 64-bit 0x0000_0000_FFFF_FFFF + 1, back-to-back -> slices 0x0000,0x0000,0x0001,0x0000, out_carry=0 on last.
REQ-035 SHALL cover: same 4-slice op with out_ready low 3 cycles at slice 1 -> in_ready drops, outputs held, same results.
REQ-036 SHALL cover: slice without in_first after reset -> err=1, result a+b with cin 0; err stays until rst.
REQ-037 SHALL cover: rst asserted after slice 1 of 4 -> no out_valid, next op with first gives correct sum.
REQ-038 SHALL cover (WIDE_ADD_SEQ_SUB_EN): 2-slice 0x0001_0000 - 0x0000_0001 -> 0xFFFF, 0x0000, out_carry=1.
